uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter (`TX_Uart`) among up to NREQ byte producers, such as the ALU result path, a command echo and a status reporter. It sits between the producers and `TX_Uart` inside the UART top level. It accepts one byte from a valid/ready requester and issues a one-cycle `tx_start` to the transmitter. It holds the byte stable until the transmitter's done tick, then re-arbitrates. A watchdog recovers the arbiter if the done tick never arrives.

## Interface
- DBIT, 8: byte width; must equal `TX_Uart` D_BIT.
- NREQ, 3: number of requesters, 2..8.
- TIMEOUT, 40000: maximum clocks in WAIT_DONE before forced release. 0 disables the watchdog.
- TO_W, 16: watchdog counter width. Must satisfy TIMEOUT < 2^TO_W.

- i_clk, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-low reset.
- i_req_valid, in, NREQ: per-requester byte valid. Once raised, it is held until accepted.
- i_req_data, in, NREQ*DBIT: requester k's byte is in bits [k*DBIT +: DBIT].
- o_req_ready, out, NREQ: one-hot accept. A transfer happens at the edge where valid and ready are both high.
- o_grant, out, NREQ: registered one-hot marking the current transmitter owner.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_tx_start, out, 1: one-cycle start pulse to `TX_Uart` i_tx_start.
- o_tx_data, out, DBIT: byte sent to `TX_Uart` i_data.
- i_tx_done_tick, in, 1: `TX_Uart` o_tx_done_tick.
- o_timeout, out, 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, START, WAIT_DONE. Reset state is IDLE.
- Reset values:
  - o_tx_start=0, o_tx_data=0, o_grant=0, o_busy=0, o_timeout=0.
  - o_req_ready=0 while reset is asserted.
  - Watchdog counter=0.
  - Round-robin pointer `last`=NREQ-1, so requester 0 wins first.
- o_req_ready is combinational:
  - It is zero outside IDLE.
  - In IDLE it is one-hot on the first set bit of i_req_valid, searching indices last+1, last+2, … modulo NREQ.
  - It may depend on i_req_valid. Requesters must not make valid depend on ready.
- IDLE transitions:
  - No valid: stay in IDLE.
  - Any valid: the accept edge latches the winner's byte into o_tx_data, sets o_grant to the winner, sets last to the winner index, and moves to START.
- START: o_tx_start=1 for exactly this cycle, then unconditional move to WAIT_DONE.
- WAIT_DONE:
  - The watchdog counter increments every cycle.
  - If i_tx_done_tick is sampled high, move to IDLE, clear o_grant and clear the counter.
  - Else if TIMEOUT≠0 and counter == TIMEOUT-1, move to IDLE, clear o_grant and the counter, and pulse o_timeout for one cycle.
  - If the done tick and the watchdog limit coincide in the same cycle, the done tick wins and o_timeout stays 0.
- i_tx_done_tick seen in IDLE or START is ignored: no state change, no effect on pointer.
- o_tx_data holds from the accept edge until the next accept. It is never modified in START or WAIT_DONE.
- Requesters that are valid but not selected keep waiting. Their data is not sampled.
- Requester valid dropping before accept is a protocol violation; the arbiter simply does not select it.
- Asynchronous reset mid-transfer returns the arbiter to IDLE immediately with all outputs at reset values. `TX_Uart` shares the reset, so no orphan frame continues.

## Timing
- Accept edge E0: o_tx_start is high in the cycle after E0, ending at edge E1. WAIT_DONE begins after E1.
- Done tick sampled at edge Ed: IDLE in the next cycle. The next accept can occur at edge Ed+1.
- Minimum spacing between consecutive o_tx_start pulses is therefore the frame time plus 2 clocks.
- Watchdog: o_timeout is asserted TIMEOUT cycles after entry into WAIT_DONE, in the cycle following the edge that leaves WAIT_DONE.
- Fairness: a continuously valid requester waits at most NREQ-1 transfers.

## Test plan
- Single request: req1 valid with 0xA5 in IDLE.
  - ready[1] is high in that same cycle.
  - One cycle later: o_tx_start=1, o_tx_data=0xA5, o_grant=3'b010.
  - Serial line carries 0xA5.
  - o_busy drops one cycle after the done tick.
- Simultaneous requests: all three valid at once after reset with 0x11, 0x22, 0x33.
  - Frames are sent in order 0x11, 0x22, 0x33.
  - Exactly three o_tx_start pulses.
- Fairness: req0 permanently valid, req2 raised during req0's first frame.
  - Grant sequence is 0, 2, 0, 2, …
  - req0 never receives two consecutive grants while req2 is waiting.
- Stray done tick: pulse i_tx_done_tick in IDLE, and again in START.
  - No state change.
  - The following frame completes normally.
- Watchdog: TIMEOUT=20, i_tx_done_tick tied low.
  - o_timeout pulses once, 20 cycles after entry into WAIT_DONE.
  - The arbiter returns to IDLE and grants the next requester.
- Reset mid-transfer: assert i_reset=0 in WAIT_DONE.
  - All outputs return to 0 asynchronously.
  - After release, requester 0 has priority again.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side signal bundle for the UART TX arbiter.
// The slave modport is the arbiter view; the master modport drives its inputs.
interface uart_tx_arbiter_if #(
  parameter int DBIT = 8,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ*DBIT-1:0] i_req_data;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ-1:0]      o_grant;
  logic                 o_busy;
  logic                 o_tx_start;
  logic [DBIT-1:0]      o_tx_data;
  logic                 i_tx_done_tick;
  logic                 o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_tx_done_tick,
    output o_req_ready, o_grant, o_busy, o_tx_start, o_tx_data, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_tx_done_tick,
    input  o_req_ready, o_grant, o_busy, o_tx_start, o_tx_data, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with a watchdog that releases the transmitter if the done tick never comes.
//
// state     | meaning
// IDLE      | no owner; o_req_ready offers the round-robin winner
// START     | o_tx_start high for this single cycle
// WAIT_DONE | frame in flight; waiting for done tick or watchdog expiry
module uart_tx_arbiter #(
  parameter int DBIT    = 8,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 40000,
  parameter int TO_W    = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_W-1:0] TO_LIM = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_last;
  logic [TO_W-1:0]   r_wdog;
  logic [NREQ-1:0]   r_grant;
  logic [DBIT-1:0]   r_tx_data;
  logic              r_tx_start;
  logic              r_timeout;

  logic [NREQ-1:0]   w_sel;
  logic [IDX_W-1:0]  w_win;
  logic              w_any;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W-1:0]  w_idx;
  logic [DBIT-1:0]   w_data;

  // Search last+1, last+2, ... modulo NREQ; the first valid index wins.
  always_comb begin
    w_sel = '0;
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ))
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      w_idx = w_sum[IDX_W-1:0];
      if (!w_any && bus.i_req_valid[w_idx]) begin
        w_any        = 1'b1;
        w_win        = w_idx;
        w_sel[w_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (w_win == IDX_W'(k))
        w_data = bus.i_req_data[k*DBIT +: DBIT];
  end

  assign bus.o_req_ready = (r_state == IDLE && i_reset) ? w_sel : '0;
  assign bus.o_grant     = r_grant;
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_tx_start  = r_tx_start;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_timeout   = r_timeout;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_last     <= IDX_W'(NREQ - 1);
      r_wdog     <= '0;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tx_data  <= w_data;
            r_grant    <= w_sel;
            r_last     <= w_win;
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_wdog  <= '0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Done tick takes priority over a coinciding watchdog expiry.
          if (bus.i_tx_done_tick) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_wdog  <= '0;
          end else if (TIMEOUT != 0 && r_wdog == TO_LIM) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, round-robin order,
// fairness, stray done ticks, watchdog, done/watchdog tie and async reset.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   nstart   = 0;
  int   n0;
  int   fseq [4] = '{0, 2, 0, 2};

  uart_tx_arbiter_if #(.DBIT(8), .NREQ(3)) bus ();

  uart_tx_arbiter #(.DBIT(8), .NREQ(3), .TIMEOUT(20), .TO_W(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_tx_start) nstart++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_req_valid    = '0;
    bus.i_req_data     = '0;
    bus.i_tx_done_tick = 1'b0;
    #1;
    chk("rst_busy",     32'(bus.o_busy),      32'h0);
    chk("rst_grant",    32'(bus.o_grant),     32'h0);
    chk("rst_tx_start", 32'(bus.o_tx_start),  32'h0);
    chk("rst_tx_data",  32'(bus.o_tx_data),   32'h0);
    chk("rst_timeout",  32'(bus.o_timeout),   32'h0);
    bus.i_req_valid = 3'b111;
    #1;
    chk("rst_ready",    32'(bus.o_req_ready), 32'h0);
    bus.i_req_valid = '0;
    #11 rst_n = 1'b1;
    tick();

    // Single request from requester 1
    bus.i_req_data  = {8'h00, 8'hA5, 8'h00};
    bus.i_req_valid = 3'b010;
    #1;
    chk("single_ready", 32'(bus.o_req_ready), 32'h2);
    chk("single_idle",  32'(bus.o_busy),      32'h0);
    tick();
    chk("single_start", 32'(bus.o_tx_start),  32'h1);
    chk("single_data",  32'(bus.o_tx_data),   32'hA5);
    chk("single_grant", 32'(bus.o_grant),     32'h2);
    chk("single_busy",  32'(bus.o_busy),      32'h1);
    chk("single_noready", 32'(bus.o_req_ready), 32'h0);
    bus.i_req_valid = '0;
    tick();
    chk("single_pulse1", 32'(bus.o_tx_start), 32'h0);
    tick();
    tick();
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    chk("single_done_busy",  32'(bus.o_busy),    32'h0);
    chk("single_done_grant", 32'(bus.o_grant),   32'h0);
    chk("single_hold_data",  32'(bus.o_tx_data), 32'hA5);

    // Simultaneous requests after reset: order 0,1,2
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    n0 = nstart;
    bus.i_req_data  = {8'h33, 8'h22, 8'h11};
    bus.i_req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rr_ready", 32'(bus.o_req_ready), 32'(1 << k));
      tick();
      chk("rr_start", 32'(bus.o_tx_start), 32'h1);
      chk("rr_data",  32'(bus.o_tx_data),  32'(8'h11 * (k + 1)));
      chk("rr_grant", 32'(bus.o_grant),    32'(1 << k));
      bus.i_req_valid[k] = 1'b0;
      tick();
      chk("rr_pulse1", 32'(bus.o_tx_start), 32'h0);
      bus.i_tx_done_tick = 1'b1;
      tick();
      bus.i_tx_done_tick = 1'b0;
      chk("rr_idle", 32'(bus.o_busy), 32'h0);
    end
    tick();
    tick();
    chk("rr_nstart", 32'(nstart - n0), 32'h3);

    // Fairness: req0 always valid, req2 raised during req0's first frame
    bus.i_req_data  = {8'h42, 8'h00, 8'h40};
    bus.i_req_valid = 3'b001;
    for (int f = 0; f < 4; f++) begin
      #1;
      chk("fair_ready", 32'(bus.o_req_ready), 32'(1 << fseq[f]));
      tick();
      chk("fair_grant", 32'(bus.o_grant), 32'(1 << fseq[f]));
      chk("fair_data",  32'(bus.o_tx_data), (fseq[f] == 0) ? 32'h40 : 32'h42);
      if (f == 0) bus.i_req_valid[2] = 1'b1;
      tick();
      bus.i_tx_done_tick = 1'b1;
      tick();
      bus.i_tx_done_tick = 1'b0;
    end
    bus.i_req_valid = '0;

    // Stray done ticks in IDLE and START
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    chk("stray_idle_busy",  32'(bus.o_busy),     32'h0);
    chk("stray_idle_start", 32'(bus.o_tx_start), 32'h0);
    bus.i_req_data  = {8'h00, 8'h5B, 8'h5A};
    bus.i_req_valid = 3'b011;
    #1;
    chk("stray_ready", 32'(bus.o_req_ready), 32'h1);
    tick();
    chk("stray_start", 32'(bus.o_tx_start), 32'h1);
    bus.i_req_valid = 3'b010;
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    chk("stray_start_busy",  32'(bus.o_busy),     32'h1);
    chk("stray_start_grant", 32'(bus.o_grant),    32'h1);
    chk("stray_start_pulse", 32'(bus.o_tx_start), 32'h0);
    tick();
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    chk("stray_done_busy", 32'(bus.o_busy),    32'h0);
    chk("stray_done_data", 32'(bus.o_tx_data), 32'h5A);

    // Watchdog: no done tick, TIMEOUT=20
    bus.i_req_data  = {8'h62, 8'h61, 8'h00};
    bus.i_req_valid = 3'b110;
    #1;
    chk("wd_ready", 32'(bus.o_req_ready), 32'h2);
    tick();
    chk("wd_data", 32'(bus.o_tx_data), 32'h61);
    bus.i_req_valid = 3'b100;
    tick();
    for (int i = 1; i < 20; i++) begin
      chk("wd_quiet", 32'(bus.o_timeout), 32'h0);
      tick();
    end
    chk("wd_last_busy", 32'(bus.o_busy),    32'h1);
    chk("wd_last_to",   32'(bus.o_timeout), 32'h0);
    tick();
    chk("wd_fire",       32'(bus.o_timeout),   32'h1);
    chk("wd_fire_busy",  32'(bus.o_busy),      32'h0);
    chk("wd_fire_grant", 32'(bus.o_grant),     32'h0);
    chk("wd_next_ready", 32'(bus.o_req_ready), 32'h4);
    tick();
    chk("wd_pulse1",   32'(bus.o_timeout),  32'h0);
    chk("wd_next_grant", 32'(bus.o_grant),  32'h4);
    chk("wd_next_data",  32'(bus.o_tx_data), 32'h62);
    chk("wd_next_start", 32'(bus.o_tx_start), 32'h1);
    bus.i_req_valid = '0;

    // Done tick coinciding with the watchdog limit: done wins
    tick();
    repeat (19) tick();
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    chk("tie_timeout", 32'(bus.o_timeout), 32'h0);
    chk("tie_busy",    32'(bus.o_busy),    32'h0);

    // Async reset mid-transfer, then requester 0 has priority again
    bus.i_req_data  = {8'h73, 8'h72, 8'h71};
    bus.i_req_valid = 3'b111;
    #1;
    chk("rstm_ready", 32'(bus.o_req_ready), 32'h1);
    tick();
    tick();
    tick();
    chk("rstm_wait_busy", 32'(bus.o_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm_busy",     32'(bus.o_busy),      32'h0);
    chk("rstm_grant",    32'(bus.o_grant),     32'h0);
    chk("rstm_data",     32'(bus.o_tx_data),   32'h0);
    chk("rstm_start",    32'(bus.o_tx_start),  32'h0);
    chk("rstm_timeout",  32'(bus.o_timeout),   32'h0);
    chk("rstm_ready0",   32'(bus.o_req_ready), 32'h0);
    #2 rst_n = 1'b1;
    #1;
    chk("rstm_prio", 32'(bus.o_req_ready), 32'h1);
    tick();
    chk("rstm_grant0", 32'(bus.o_grant),   32'h1);
    chk("rstm_data0",  32'(bus.o_tx_data), 32'h71);
    bus.i_req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
